// File: rtl/taxi_pkg.sv
// Shared taxi types and widths.
// Edge/distance width is common to the pulse generator and the meter.
package taxi_pkg;

  localparam int TAXI_CNT_W = 18;
  localparam int TAXI_SPD_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_HOLD,
    ST_DONE
  } state_e;

endpackage

// File: rtl/taxi_tick_timer.sv
// Half-period timer for the wheel signal.
// Emits a one-cycle tick each time a half period has elapsed.
module taxi_tick_timer
  import taxi_pkg::*;
#(
  parameter int BASE  = 50,
  parameter int SPD_W = TAXI_SPD_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run_i,
  input  logic             clr_i,
  input  logic [SPD_W-1:0] speed_i,
  output logic             tick_o
);

  localparam int TMR_W = $clog2(BASE * (2 ** SPD_W) + 1);

  logic [TMR_W-1:0] half;
  logic [TMR_W-1:0] timer_q;
  logic [TMR_W-1:0] timer_d;
  logic             moving;

  assign half = TMR_W'(BASE)
              * (TMR_W'(2 ** SPD_W) - TMR_W'(speed_i));

  // Speed zero freezes the count so a paused trip resumes mid-period.
  assign moving = run_i && (speed_i != '0);
  assign tick_o = moving && (timer_q >= half - TMR_W'(1));

  always_comb begin
    timer_d = timer_q;
    if (clr_i) begin
      timer_d = '0;
    end else if (tick_o) begin
      timer_d = '0;
    end else if (moving) begin
      timer_d = timer_q + TMR_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end

endmodule

// File: rtl/taxi_motor_gen.sv
// Wheel-sensor pulse generator feeding the meter's motor input.
// Trip FSM, motor flip-flop, edge counter and target register.
module taxi_motor_gen
  import taxi_pkg::*;
#(
  parameter int BASE  = 50,
  parameter int SPD_W = TAXI_SPD_W,
  parameter int CNT_W = TAXI_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [SPD_W-1:0] speed,
  input  logic [CNT_W-1:0] target,
  output logic             motor,
  output logic [CNT_W-1:0] edge_cnt,
  output logic             busy,
  output logic             done
);

  state_e           state_q;
  state_e           state_d;
  logic             motor_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] tgt_q;
  logic             active;
  logic             launch;
  logic             tick;
  logic             hit;

  assign active = (state_q == ST_RUN) || (state_q == ST_HOLD);
  assign launch = start && !stop
               && ((state_q == ST_IDLE) || (state_q == ST_DONE));

  // Stop suppresses any tick landing in the same cycle.
  taxi_tick_timer #(
    .BASE  (BASE),
    .SPD_W (SPD_W)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .run_i   (active && !stop),
    .clr_i   (!active),
    .speed_i (speed),
    .tick_o  (tick)
  );

  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
  assign hit     = tick && (tgt_q != '0) && (cnt_inc == tgt_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (launch) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (stop)              state_d = ST_IDLE;
        else if (hit)          state_d = ST_DONE;
        else if (speed == '0)  state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (stop)              state_d = ST_IDLE;
        else if (hit)          state_d = ST_DONE;
        else if (speed != '0)  state_d = ST_RUN;
      end
      ST_DONE: begin
        if (stop)        state_d = ST_IDLE;
        else if (launch) state_d = ST_RUN;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (1'b1)
      (state_q == ST_RUN),
      (state_q == ST_HOLD): busy = 1'b1;
      (state_q == ST_DONE): done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      motor_q <= 1'b0;
      cnt_q   <= '0;
      tgt_q   <= '0;
    end else begin
      if (tick) begin
        motor_q <= ~motor_q;
      end
      if (launch) begin
        cnt_q <= '0;
        tgt_q <= target;
      end else if (tick) begin
        cnt_q <= cnt_inc;
      end
    end
  end

  assign motor    = motor_q;
  assign edge_cnt = cnt_q;

endmodule
